// File: rtl/video_mon_pkg.sv
// video_mon_pkg: shared FSM states and CRC-32 constants for the video frame monitor
package video_mon_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_VSYNC, CAPTURE, DONE} state_t;
  localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;
endpackage

// File: rtl/video_frame_monitor_if.sv
// video_frame_monitor_if: VCE pixel/sync stream, capture control and per-frame results
interface video_frame_monitor_if #(
  parameter int COLOR_W = 3,
  parameter int CNT_W = 11,
  parameter int FC_W = 2
);
  logic [COLOR_W-1:0] R, G, B;
  logic HSYNC_n, VSYNC_n, start, abort;
  logic frame_valid;
  logic [FC_W-1:0] frame_count;
  logic [CNT_W-1:0] line_len, line_count;
  logic [31:0] frame_crc;
  logic sync_error, done;
  modport master (
    output R, G, B, HSYNC_n, VSYNC_n, start, abort,
    input frame_valid, frame_count, line_len, line_count, frame_crc, sync_error, done
  );
  modport slave (
    input R, G, B, HSYNC_n, VSYNC_n, start, abort,
    output frame_valid, frame_count, line_len, line_count, frame_crc, sync_error, done
  );
endinterface

// File: rtl/crc32_step.sv
// crc32_step: one combinational CRC-32 update over DATA_W bits, MSB first, unreflected
module crc32_step
  import video_mon_pkg::*;
#(
  parameter int DATA_W = 9
) (
  input  logic [31:0]       crc_in,
  input  logic [DATA_W-1:0] data,
  output logic [31:0]       crc_out
);
  always_comb begin
    crc_out = crc_in;
    for (int i = DATA_W - 1; i >= 0; i--)
      crc_out = {crc_out[30:0], 1'b0} ^ ((crc_out[31] ^ data[i]) ? CRC_POLY : 32'h0);
  end
endmodule

// File: rtl/video_frame_monitor.sv
// video_frame_monitor: measures line timing, line count and pixel CRC of captured video frames
module video_frame_monitor
  import video_mon_pkg::*;
#(
  parameter int COLOR_W = 3,
  parameter int CNT_W = 11,
  parameter int NUM_FRAMES = 3,
  localparam int FC_W = $clog2(NUM_FRAMES + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [COLOR_W-1:0] R,
  input  logic [COLOR_W-1:0] G,
  input  logic [COLOR_W-1:0] B,
  input  logic               HSYNC_n,
  input  logic               VSYNC_n,
  input  logic               start,
  input  logic               abort,
  output logic               frame_valid,
  output logic [FC_W-1:0]    frame_count,
  output logic [CNT_W-1:0]   line_len,
  output logic [CNT_W-1:0]   line_count,
  output logic [31:0]        frame_crc,
  output logic               sync_error,
  output logic               done
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  state_t state_q;
  logic hs_prev_q, vs_prev_q, hs_fall, vs_fall;
  logic [31:0] crc_q, crc_b, crc_d;
  logic [CNT_W-1:0] lines_q, lines_b, lines_d, cyc_q, cyc_b, cyc_d, len_q, len_b, len_d;
  logic ovf_q, ovf_b, ovf_d, err_q, err_b, err_d, lines_sat, cyc_sat;
  logic frame_valid_q, sync_error_q, done_q;
  logic [FC_W-1:0] frame_count_q;
  logic [CNT_W-1:0] line_len_q, line_count_q;
  logic [31:0] frame_crc_q;
  assign hs_fall = hs_prev_q & ~HSYNC_n;
  assign vs_fall = vs_prev_q & ~VSYNC_n;
  // A VSYNC edge restarts the accumulators from scratch but still counts its own cycle
  always_comb begin
    crc_b = vs_fall ? CRC_INIT : crc_q;
    lines_b = vs_fall ? '0 : lines_q;
    cyc_b = vs_fall ? '0 : cyc_q;
    len_b = vs_fall ? '0 : len_q;
    ovf_b = vs_fall ? 1'b0 : ovf_q;
    err_b = vs_fall ? 1'b0 : err_q;
    lines_sat = lines_b == CNT_MAX;
    cyc_sat = cyc_b == CNT_MAX;
    lines_d = (hs_fall && !lines_sat) ? lines_b + CNT_ONE : lines_b;
    cyc_d = hs_fall ? CNT_ONE : cyc_sat ? cyc_b : cyc_b + CNT_ONE;
    ovf_d = !hs_fall && (ovf_b || cyc_sat);
    len_d = (hs_fall && lines_b == CNT_ONE) ? cyc_b : len_b;
    err_d = err_b || (hs_fall && (lines_sat || (lines_b != '0 && ovf_b) ||
                                  (lines_b > CNT_ONE && cyc_b != len_b)));
  end
  crc32_step #(.DATA_W(3 * COLOR_W)) u_crc (.crc_in(crc_b), .data({R, G, B}), .crc_out(crc_d));
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      hs_prev_q <= 1'b1;
      vs_prev_q <= 1'b1;
      crc_q <= CRC_INIT;
      lines_q <= '0;
      cyc_q <= '0;
      len_q <= '0;
      ovf_q <= 1'b0;
      err_q <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_count_q <= '0;
      line_len_q <= '0;
      line_count_q <= '0;
      frame_crc_q <= CRC_INIT;
      sync_error_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      hs_prev_q <= HSYNC_n;
      vs_prev_q <= VSYNC_n;
      frame_valid_q <= 1'b0;
      if (abort) begin
        state_q <= IDLE;
        frame_count_q <= '0;
        done_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: if (start) state_q <= WAIT_VSYNC;
          WAIT_VSYNC, CAPTURE: begin
            crc_q <= crc_d;
            lines_q <= lines_d;
            cyc_q <= cyc_d;
            len_q <= len_d;
            ovf_q <= ovf_d;
            err_q <= err_d;
            if (vs_fall && state_q == WAIT_VSYNC) state_q <= CAPTURE;
            if (vs_fall && state_q == CAPTURE) begin
              line_len_q <= len_q;
              line_count_q <= lines_q;
              frame_crc_q <= crc_q;
              sync_error_q <= err_q;
              frame_count_q <= frame_count_q + FC_W'(1);
              frame_valid_q <= 1'b1;
              if (frame_count_q == FC_W'(NUM_FRAMES - 1)) begin
                state_q <= DONE;
                done_q <= 1'b1;
              end
            end
          end
          DONE: ;
        endcase
      end
    end
  end
  assign frame_valid = frame_valid_q;
  assign frame_count = frame_count_q;
  assign line_len = line_len_q;
  assign line_count = line_count_q;
  assign frame_crc = frame_crc_q;
  assign sync_error = sync_error_q;
  assign done = done_q;
endmodule

// File: tb/tb_video_frame_monitor.sv
// tb_video_frame_monitor: directed frames against a CRC/timing reference, second instance with CNT_W=4
module tb_video_frame_monitor;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;
  int nv = 0;
  int nv2 = 0;
  int base, base2;
  logic [10:0] m_len[32], m_lc[32];
  logic [31:0] m_crc[32], m2_crc[32];
  logic m_err[32], m2_err[32];
  logic [3:0] m2_len[32], m2_lc[32];
  logic [31:0] fcrc[4];
  logic fv2, err2, done2;
  logic [1:0] fc2;
  logic [3:0] len2, lc2;
  logic [31:0] crc2;

  always #5 clock = ~clock;

  video_frame_monitor_if #(.COLOR_W(3), .CNT_W(11), .FC_W(2)) vif ();

  video_frame_monitor #(.COLOR_W(3), .CNT_W(11), .NUM_FRAMES(3)) dut (
    .clock(clock), .reset(reset), .R(vif.R), .G(vif.G), .B(vif.B),
    .HSYNC_n(vif.HSYNC_n), .VSYNC_n(vif.VSYNC_n), .start(vif.start), .abort(vif.abort),
    .frame_valid(vif.frame_valid), .frame_count(vif.frame_count), .line_len(vif.line_len),
    .line_count(vif.line_count), .frame_crc(vif.frame_crc), .sync_error(vif.sync_error),
    .done(vif.done)
  );

  video_frame_monitor #(.COLOR_W(3), .CNT_W(4), .NUM_FRAMES(3)) dut2 (
    .clock(clock), .reset(reset), .R(vif.R), .G(vif.G), .B(vif.B),
    .HSYNC_n(vif.HSYNC_n), .VSYNC_n(vif.VSYNC_n), .start(vif.start), .abort(vif.abort),
    .frame_valid(fv2), .frame_count(fc2), .line_len(len2), .line_count(lc2),
    .frame_crc(crc2), .sync_error(err2), .done(done2)
  );

  always @(negedge clock) begin
    if (vif.frame_valid) begin
      if (nv < 32) begin
        m_len[nv] = vif.line_len;
        m_lc[nv] = vif.line_count;
        m_crc[nv] = vif.frame_crc;
        m_err[nv] = vif.sync_error;
      end
      nv++;
    end
    if (fv2) begin
      if (nv2 < 32) begin
        m2_len[nv2] = len2;
        m2_lc[nv2] = lc2;
        m2_crc[nv2] = crc2;
        m2_err[nv2] = err2;
      end
      nv2++;
    end
  end

  function automatic logic [31:0] crc_ref(input logic [31:0] c, input logic [8:0] d);
    for (int i = 8; i >= 0; i--)
      c = {c[30:0], 1'b0} ^ ((c[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    return c;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n);
    vif.HSYNC_n = 1'b1;
    vif.VSYNC_n = 1'b1;
    repeat (n) tick();
  endtask

  task automatic pulse_start();
    vif.start = 1'b1;
    tick();
    vif.start = 1'b0;
  endtask

  task automatic pulse_abort();
    vif.abort = 1'b1;
    tick();
    vif.abort = 1'b0;
  endtask

  // Frame = nl lines of ll clocks (line long_j one clock longer); VSYNC and HSYNC fall together at its start
  task automatic run_frame(input int idx, input int nl, input int ll, input int long_j, input bit pat);
    logic [31:0] c;
    logic [8:0] px;
    int t;
    c = 32'hFFFFFFFF;
    t = 0;
    for (int j = 0; j < nl; j++)
      for (int k = 0; k < ll + ((j == long_j) ? 1 : 0); k++) begin
        px = pat ? 9'(t * 37 + 5) : 9'd0;
        {vif.R, vif.G, vif.B} = px;
        vif.HSYNC_n = !(k < 2);
        vif.VSYNC_n = !(j == 0 && k < 2);
        c = crc_ref(c, px);
        t++;
        tick();
      end
    fcrc[idx] = c;
    {vif.R, vif.G, vif.B} = 9'd0;
  endtask

  initial begin
    {vif.R, vif.G, vif.B} = 9'd0;
    vif.HSYNC_n = 1'b1;
    vif.VSYNC_n = 1'b1;
    vif.start = 1'b0;
    vif.abort = 1'b1;
    repeat (3) tick();
    chk("rst_valid", vif.frame_valid, 0);
    chk("rst_count", vif.frame_count, 0);
    chk("rst_len", vif.line_len, 0);
    chk("rst_lines", vif.line_count, 0);
    chk("rst_crc", vif.frame_crc, 32'hFFFFFFFF);
    chk("rst_err", vif.sync_error, 0);
    chk("rst_done", vif.done, 0);
    vif.abort = 1'b0;
    reset = 1'b0;
    tick();
    pulse_start();
    base = nv;
    for (int f = 0; f < 3; f++) run_frame(f, 10, 16, -1, 1'b0);
    run_frame(3, 1, 16, -1, 1'b0);
    idle(4);
    chk("a_pulses", nv - base, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("a_len%0d", i), m_len[base+i], 16);
      chk($sformatf("a_lines%0d", i), m_lc[base+i], 10);
      chk($sformatf("a_err%0d", i), m_err[base+i], 0);
      chk($sformatf("a_crc%0d", i), m_crc[base+i], fcrc[0]);
    end
    chk("a_done", vif.done, 1);
    chk("a_count", vif.frame_count, 3);
    pulse_start();
    run_frame(3, 10, 16, -1, 1'b1);
    run_frame(3, 1, 16, -1, 1'b1);
    idle(3);
    chk("done_start_ignored", nv - base, 3);
    chk("done_held", vif.done, 1);
    pulse_abort();
    chk("abort_done", vif.done, 0);
    chk("abort_count", vif.frame_count, 0);
    chk("abort_keep_lines", vif.line_count, 10);
    chk("abort_keep_crc", vif.frame_crc, fcrc[0]);
    pulse_start();
    base = nv;
    run_frame(0, 10, 16, -1, 1'b1);
    run_frame(3, 5, 16, -1, 1'b1);
    pulse_abort();
    idle(5);
    chk("b1_pulses", nv - base, 1);
    chk("b1_crc", m_crc[base], fcrc[0]);
    chk("b1_count", vif.frame_count, 0);
    chk("b1_valid", vif.frame_valid, 0);
    pulse_start();
    base = nv;
    run_frame(0, 10, 16, -1, 1'b1);
    run_frame(1, 10, 16, 3, 1'b1);
    run_frame(2, 10, 16, -1, 1'b1);
    run_frame(3, 1, 16, -1, 1'b1);
    idle(3);
    chk("b2_pulses", nv - base, 3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("b2_len%0d", i), m_len[base+i], 16);
      chk($sformatf("b2_lines%0d", i), m_lc[base+i], 10);
      chk($sformatf("b2_err%0d", i), m_err[base+i], (i == 1) ? 1 : 0);
      chk($sformatf("b2_crc%0d", i), m_crc[base+i], fcrc[i]);
    end
    chk("b2_done", vif.done, 1);
    pulse_abort();
    pulse_start();
    base = nv;
    run_frame(0, 10, 16, -1, 1'b0);
    run_frame(3, 4, 16, -1, 1'b0);
    reset = 1'b1;
    tick();
    chk("c_valid", vif.frame_valid, 0);
    chk("c_count", vif.frame_count, 0);
    chk("c_crc", vif.frame_crc, 32'hFFFFFFFF);
    chk("c_lines", vif.line_count, 0);
    reset = 1'b0;
    idle(5);
    chk("c_pulses", nv - base, 1);
    pulse_start();
    base = nv;
    base2 = nv2;
    run_frame(0, 10, 20, -1, 1'b1);
    run_frame(3, 1, 20, -1, 1'b1);
    idle(3);
    chk("d_pulses", nv - base, 1);
    chk("d_len", m_len[base], 20);
    chk("d_err", m_err[base], 0);
    chk("d2_pulses", nv2 - base2, 1);
    chk("d2_len_sat", m2_len[base2], 15);
    chk("d2_err", m2_err[base2], 1);
    chk("d2_lines", m2_lc[base2], 10);
    chk("d2_crc", m2_crc[base2], fcrc[0]);
    chk("d2_count", fc2, 1);
    chk("d2_done", done2, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/video_frame_monitor.md
VIDEO_FRAME_MONITOR -- requirements
Module: video_frame_monitor

Interface
REQ-001 SHALL have parameter COLOR_W, default 3, meaning bits per colour channel.
REQ-002 SHALL have parameter CNT_W, default 11, meaning width of line-length and line-count counters.
REQ-003 SHALL have parameter NUM_FRAMES, default 3, meaning complete frames to capture before done.
REQ-004 SHALL have port clock, input, 1, meaning the single clock; all logic is rising-edge.
REQ-005 SHALL have port reset, input, 1, meaning reset; it is synchronous and active-high.
REQ-006 SHALL have ports R, G, B, input, COLOR_W each, meaning pixel colour from the VCE.
REQ-007 SHALL have ports HSYNC_n and VSYNC_n, input, 1 each, meaning active-low syncs.
REQ-008 SHALL have ports start and abort, input, 1 each, meaning start and cancel capture.
REQ-009 SHALL have port frame_valid, output, 1, meaning one-cycle pulse when a frame's results latch.
REQ-010 SHALL have port frame_count, output, $clog2(NUM_FRAMES+1), meaning frames completed.
REQ-011 SHALL have port line_len, output, CNT_W, meaning clocks per line in the last frame.
REQ-012 SHALL have port line_count, output, CNT_W, meaning lines in the last frame.
REQ-013 SHALL have port frame_crc, output, 32, meaning CRC of the last frame's pixels.
REQ-014 SHALL have ports sync_error and done, output, 1 each, meaning line-length mismatch (sticky per frame) and capture finished.

Function
REQ-015 SHALL detect a falling edge on a sync when prev=1 and cur=0; the prev registers reset to 1.
REQ-016 SHALL implement the states IDLE, WAIT_VSYNC, CAPTURE and DONE.
REQ-017 SHALL move IDLE->WAIT_VSYNC on start, WAIT_VSYNC->CAPTURE on a VSYNC falling edge, and CAPTURE->DONE on the frame end that makes frame_count==NUM_FRAMES.
REQ-018 SHALL treat abort as overriding in every state: go to IDLE, clear frame_count and done, and keep the last latched results.
REQ-019 SHALL ignore start outside IDLE; a start in DONE needs abort first.
REQ-020 SHALL, in CAPTURE, update a CRC every cycle with {R,G,B} (MSB first, 3*COLOR_W bits), using poly 0x04C11DB7, init 0xFFFFFFFF, no reflection and no final XOR.
REQ-021 SHALL have the CRC cover the cycles from the frame-start VSYNC edge cycle (inclusive) to the next VSYNC edge cycle (exclusive).
REQ-022 SHALL set line_count to the number of HSYNC falling edges in that same window; an HSYNC edge in the VSYNC edge cycle belongs to the new frame.
REQ-023 SHALL set line_len to the cycle distance between the first two HSYNC edges of the frame, and 0 if fewer than two.
REQ-024 SHALL set sync_error for the frame if any later complete line's distance differs from line_len.
REQ-025 SHALL saturate counters at 2^CNT_W-1 with no wrap, and saturation SHALL set sync_error.
REQ-026 SHALL, on a VSYNC edge in CAPTURE, latch line_len, line_count, frame_crc and sync_error, increment frame_count and reinitialise the accumulators, all in the same edge.
REQ-027 SHALL make the latched outputs and the frame_valid pulse visible the cycle after the VSYNC edge is detected.
REQ-028 SHALL hold done=1 in DONE and ignore the pixel and sync inputs there.

Reset
REQ-029 SHALL set state to IDLE on reset.
REQ-030 SHALL drive frame_valid, frame_count, line_len, line_count, sync_error and done to 0 on reset.
REQ-031 SHALL drive frame_crc to 0xFFFFFFFF on reset.
REQ-032 SHALL give reset priority over abort and start in the same cycle.
REQ-033 SHALL, on reset mid-CAPTURE, discard the partial frame and emit no frame_valid.

Structure
REQ-034 SHALL put the state enum, the CRC polynomial and init constants in the shared package video_mon_pkg.
REQ-035 SHALL implement the CRC as one combinational sub-module, crc32_step (parameter DATA_W; inputs crc_in and data; output crc_out), instantiated with DATA_W=3*COLOR_W.
REQ-036 SHALL keep the edge detectors, counters and FSM in video_frame_monitor.

Verification
REQ-037 Regular timing of 16-clock lines, 10 lines per frame, NUM_FRAMES=3 -> three frame_valid pulses, each with line_len=16, line_count=10, sync_error=0, then done=1 with frame_count=3.
REQ-038 Constant RGB=0 over the same timing -> frame_crc equals the software model value and is identical across all three frames.
REQ-039 One 17-clock line inside frame 2 -> sync_error=1 on frame 2 only and 0 on frames 1 and 3.
REQ-040 HSYNC and VSYNC edges in the same cycle -> that line is counted in the new frame, giving line_count=10 rather than 11.
REQ-041 abort issued mid-frame 2 -> state IDLE, frame_count=0, no pulse; a later start re-arms and captures three frames.
REQ-042 CNT_W=4 with 20-clock lines -> line_len=15 (saturated) and sync_error=1.
